// File: rtl/fft8_pkg.sv
// Shared types, twiddle constants and index helpers for the 8-point FFT stage feeders.
// Latency: none, declarations only.
// Backpressure: not applicable.
package fft8_pkg;

    localparam int CPLX_W = 32;

    typedef logic [CPLX_W-1:0] cplx_t;

    // {imag, real}, signed, 1.0 = 256
    localparam cplx_t W0 = 32'h0000_0100;   // ( 0,    256)
    localparam cplx_t W1 = 32'hFF4B_00B5;   // (-181,  181)
    localparam cplx_t W2 = 32'hFF00_0000;   // (-256,  0)
    localparam cplx_t W3 = 32'hFF4B_FF4B;   // (-181, -181)

    typedef enum logic {
        RD_IDLE,
        RD_ISSUE
    } rd_state_t;

    typedef struct packed {
        logic       vld;
        cplx_t      data1;
        logic [2:0] top;
        logic [2:0] bot;
        logic       last;
    } dl_ent_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

    function automatic cplx_t twiddle(input logic [1:0] idx);
        case (idx)
            2'd0:    return W0;
            2'd1:    return W1;
            2'd2:    return W2;
            default: return W3;
        endcase
    endfunction

endpackage

// File: rtl/fft8_delay_line.sv
// Fixed-depth shift register that realigns issued operands with the multiplier output.
// Latency: DEPTH cycles, every stage clocked every cycle.
// Backpressure: none; reset clears all stages.
module fft8_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft8_stage_feeder.sv
// Ping-pong frame buffer feeding one radix-2 stage of the 8-point FFT with pairs and twiddles.
// Latency: last sample in at T -> pair 0 at T+1, its data1/addrs at T+1+CMPY_LAT.
// Backpressure: s_ready drops only while both banks hold frames; multiplier side never stalls.
module fft8_stage_feeder
    import fft8_pkg::*;
#(
    parameter int STAGE    = 0,
    parameter int BITREV   = 1,
    parameter int CMPY_LAT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [CPLX_W-1:0] s_data,
    output logic              s_ready,
    output logic [CPLX_W-1:0] data2,
    output logic [CPLX_W-1:0] w,
    output logic              enable_1,
    output logic              enable_2,
    output logic [CPLX_W-1:0] data1,
    output logic [2:0]        top_addr,
    output logic [2:0]        bot_addr,
    output logic              frame_done
);

    localparam int SPAN    = 1 << STAGE;
    localparam int TW_STEP = 4 >> STAGE;

    cplx_t      mem [2][8];
    logic       wr_bank;
    logic       rd_bank;
    logic [2:0] wr_cnt;
    logic [2:0] wr_addr;
    logic [1:0] full;
    logic [1:0] bank_rdy;
    logic [1:0] pair;
    logic       wr_fire;
    logic       wr_last;
    logic       issue;
    logic       pair_last;
    logic [2:0] top_idx;
    logic [2:0] bot_idx;
    logic [1:0] tw_idx;
    rd_state_t  state;
    rd_state_t  state_nxt;
    dl_ent_t    dl_in;
    dl_ent_t    dl_out;

    assign s_ready = ~rst & ~full[wr_bank];
    assign wr_fire = s_valid & s_ready;
    assign wr_last = wr_fire & (wr_cnt == 3'd7);
    assign wr_addr = (BITREV != 0) ? bitrev3(wr_cnt) : wr_cnt;

    // A bank is ready in the cycle its last sample lands, so issue follows with no bubble.
    assign bank_rdy[0] = full[0] | (wr_last & ~wr_bank);
    assign bank_rdy[1] = full[1] | (wr_last & wr_bank);

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_bank][wr_addr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_cnt  <= 3'd0;
            full    <= 2'b00;
        end else begin
            if (wr_fire) wr_cnt <= wr_cnt + 3'd1;
            if (wr_last) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (pair_last) full[rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RD_IDLE;
            rd_bank <= 1'b0;
            pair    <= 2'd0;
        end else begin
            state <= state_nxt;
            if (issue)     pair    <= pair + 2'd1;
            if (pair_last) rd_bank <= ~rd_bank;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE:  if (bank_rdy[rd_bank]) state_nxt = RD_ISSUE;
            RD_ISSUE: if (pair == 2'd3 && !bank_rdy[~rd_bank]) state_nxt = RD_IDLE;
            default:  state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        issue     = (state == RD_ISSUE);
        pair_last = issue & (pair == 2'd3);
        top_idx   = 3'(((int'(pair) >> STAGE) * 2 * SPAN) + (int'(pair) & (SPAN - 1)));
        bot_idx   = 3'(int'(top_idx) + SPAN);
        tw_idx    = 2'((int'(pair) & (SPAN - 1)) * TW_STEP);
        enable_1  = issue;
        enable_2  = issue;
        data2     = issue ? mem[rd_bank][bot_idx] : '0;
        w         = issue ? twiddle(tw_idx) : '0;
        dl_in     = '0;
        if (issue) begin
            dl_in.vld   = 1'b1;
            dl_in.data1 = mem[rd_bank][top_idx];
            dl_in.top   = top_idx;
            dl_in.bot   = bot_idx;
            dl_in.last  = pair_last;
        end
    end

    fft8_delay_line #(
        .WIDTH($bits(dl_ent_t)),
        .DEPTH(CMPY_LAT)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign data1      = dl_out.data1;
    assign top_addr   = dl_out.top;
    assign bot_addr   = dl_out.bot;
    assign frame_done = dl_out.vld & dl_out.last;

endmodule

// File: tb/tb_fft8_stage_feeder.sv
// Bench for two feeder configurations (stage 0 bit-reversed, stage 2 natural) on a shared input.
module tb_fft8_stage_feeder;

    localparam int LAT0 = 6;
    localparam int LAT1 = 3;
    localparam int K    = 1000000;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] w;
        logic [2:0]  top;
        logic [2:0]  bot;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        s_ready_o [2];
    logic        en1_o [2];
    logic        en2_o [2];
    logic        fd_o [2];
    logic [31:0] d2_o [2];
    logic [31:0] w_o [2];
    logic [31:0] d1_o [2];
    logic [2:0]  top_o [2];
    logic [2:0]  bot_o [2];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] cur [8];
    int          cnt = 0;
    int          next_free = 0;
    int          frames_sched = 0;
    int          hq_t [$];
    int          hq_e [$];
    exp_t        exp_iss [int];
    logic [31:0] tw_tab [4] = '{32'h0000_0100, 32'hFF4B_00B5, 32'hFF00_0000, 32'hFF4B_FF4B};

    always #5 clk = ~clk;

    fft8_stage_feeder #(.STAGE(0), .BITREV(1), .CMPY_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_o[0]),
        .data2(d2_o[0]), .w(w_o[0]), .enable_1(en1_o[0]), .enable_2(en2_o[0]),
        .data1(d1_o[0]), .top_addr(top_o[0]), .bot_addr(bot_o[0]), .frame_done(fd_o[0])
    );

    fft8_stage_feeder #(.STAGE(2), .BITREV(0), .CMPY_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_o[1]),
        .data2(d2_o[1]), .w(w_o[1]), .enable_1(en1_o[1]), .enable_2(en2_o[1]),
        .data1(d1_o[1]), .top_addr(top_o[1]), .bot_addr(bot_o[1]), .frame_done(fd_o[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int brev(input int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    // Reference: a finished frame is issued as soon as the read side is free, four pairs per frame.
    task automatic schedule_frame(input int t_end);
        int          s, st, span, g, k, top;
        logic [31:0] m [8];
        exp_t        e;
        s = (t_end + 1 > next_free) ? t_end + 1 : next_free;
        for (int d = 0; d < 2; d++) begin
            st   = (d == 0) ? 0 : 2;
            span = 1 << st;
            for (int a = 0; a < 8; a++) m[a] = (d == 0) ? cur[brev(a)] : cur[a];
            for (int p = 0; p < 4; p++) begin
                g      = p >> st;
                k      = p % span;
                top    = g * 2 * span + k;
                e.d1   = m[top];
                e.d2   = m[top + span];
                e.w    = tw_tab[k * (4 >> st)];
                e.top  = 3'(top);
                e.bot  = 3'(top + span);
                e.last = (p == 3);
                exp_iss[d * K + s + p] = e;
            end
        end
        next_free = s + 4;
        hq_t.push_back(t_end);
        hq_e.push_back(s + 3);
        frames_sched++;
    endtask

    // One clock: drive inputs, check both DUTs against the reference, then advance the reference.
    task automatic step(input bit v, input logic [31:0] d, input bit r);
        bit   exp_rdy;
        int   held, key;
        int   dk [$];
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst = r;
        s_valid = v;
        s_data = d;
        #3;
        while (hq_e.size() > 0 && hq_e[0] < cyc) begin
            void'(hq_t.pop_front());
            void'(hq_e.pop_front());
        end
        held = 0;
        foreach (hq_t[i]) if (hq_t[i] < cyc && hq_e[i] >= cyc) held++;
        exp_rdy = !r && held < 2;
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (s_ready_o[u] !== exp_rdy) begin
                n_bad++;
                $display("FAIL s_ready dut%0d cyc %0d: got %b want %b", u, cyc, s_ready_o[u], exp_rdy);
            end
            if (!r) begin
                key = u * K + cyc;
                if (exp_iss.exists(key)) begin
                    e = exp_iss[key];
                    n_cmp++;
                    if (en1_o[u] !== 1'b1 || en2_o[u] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL enable dut%0d cyc %0d: got %b%b want 11", u, cyc, en1_o[u], en2_o[u]);
                    end
                    n_cmp++;
                    if (d2_o[u] !== e.d2) begin
                        n_bad++;
                        $display("FAIL data2 dut%0d cyc %0d: got %h want %h", u, cyc, d2_o[u], e.d2);
                    end
                    n_cmp++;
                    if (w_o[u] !== e.w) begin
                        n_bad++;
                        $display("FAIL w dut%0d cyc %0d: got %h want %h", u, cyc, w_o[u], e.w);
                    end
                end else begin
                    n_cmp++;
                    if (en1_o[u] !== 1'b0 || en2_o[u] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL idle_enable dut%0d cyc %0d: got %b%b want 00", u, cyc, en1_o[u], en2_o[u]);
                    end
                end
                key = u * K + cyc - lat_of(u);
                if (exp_iss.exists(key)) begin
                    e = exp_iss[key];
                    n_cmp++;
                    if (d1_o[u] !== e.d1) begin
                        n_bad++;
                        $display("FAIL data1 dut%0d cyc %0d: got %h want %h", u, cyc, d1_o[u], e.d1);
                    end
                    n_cmp++;
                    if (top_o[u] !== e.top || bot_o[u] !== e.bot) begin
                        n_bad++;
                        $display("FAIL addrs dut%0d cyc %0d: got %0d/%0d want %0d/%0d", u, cyc,
                                 top_o[u], bot_o[u], e.top, e.bot);
                    end
                    n_cmp++;
                    if (fd_o[u] !== e.last) begin
                        n_bad++;
                        $display("FAIL frame_done dut%0d cyc %0d: got %b want %b", u, cyc, fd_o[u], e.last);
                    end
                end else begin
                    n_cmp++;
                    if (fd_o[u] !== 1'b0 || d1_o[u] !== 32'd0) begin
                        n_bad++;
                        $display("FAIL idle_data1 dut%0d cyc %0d: got %b/%h want 0/0", u, cyc, fd_o[u], d1_o[u]);
                    end
                end
            end
        end
        if (r) begin
            cnt = 0;
            next_free = 0;
            hq_t.delete();
            hq_e.delete();
            foreach (exp_iss[kk]) if ((kk % K) > cyc - lat_of(kk / K)) dk.push_back(kk);
            foreach (dk[i]) exp_iss.delete(dk[i]);
        end else if (v && exp_rdy) begin
            cur[cnt] = d;
            cnt++;
            if (cnt == 8) begin
                schedule_frame(cyc);
                cnt = 0;
            end
        end
    endtask

    task automatic test_reset;
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (s_ready_o[u] !== 1'b1 || en1_o[u] !== 1'b0 || d2_o[u] !== 32'd0 || w_o[u] !== 32'd0 ||
                d1_o[u] !== 32'd0 || top_o[u] !== 3'd0 || bot_o[u] !== 3'd0 || fd_o[u] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got rdy=%b en=%b d2=%h w=%h d1=%h top=%0d bot=%0d fd=%b want 1,0,0,0,0,0,0,0",
                         u, s_ready_o[u], en1_o[u], d2_o[u], w_o[u], d1_o[u], top_o[u], bot_o[u], fd_o[u]);
            end
        end
    endtask

    // Frame of samples 0..7, optionally preceded by a partial frame that a reset discards.
    task automatic test_known_frame(input int partial_len);
        int          t_last, o, p, en_seen;
        int          first_en [2];
        int          fd_at [2];
        logic [31:0] c_d2 [2][4];
        logic [31:0] c_w [2][4];
        logic [31:0] c_d1 [2][4];
        logic [2:0]  c_top [2][4];
        logic [2:0]  c_bot [2][4];
        int          x_d2 [2][4]  = '{'{4, 6, 5, 7}, '{4, 5, 6, 7}};
        int          x_d1 [2][4]  = '{'{0, 2, 1, 3}, '{0, 1, 2, 3}};
        int          x_top [2][4] = '{'{0, 2, 4, 6}, '{0, 1, 2, 3}};
        int          x_bot [2][4] = '{'{1, 3, 5, 7}, '{4, 5, 6, 7}};
        logic [31:0] x_w [2][4]   = '{'{32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100},
                                      '{32'h0000_0100, 32'hFF4B_00B5, 32'hFF00_0000, 32'hFF4B_FF4B}};
        step(1'b0, 32'd0, 1'b1);
        if (partial_len > 0) begin
            en_seen = 0;
            for (int i = 0; i < partial_len; i++) begin
                step(1'b1, $urandom, 1'b0);
                if (en1_o[0] || en1_o[1]) en_seen++;
            end
            step(1'b0, 32'd0, 1'b1);
            for (int i = 0; i < 3; i++) begin
                step(1'b0, 32'd0, 1'b0);
                if (en1_o[0] || en1_o[1]) en_seen++;
            end
            n_cmp++;
            if (en_seen != 0) begin
                n_bad++;
                $display("FAIL partial_enables: got %0d want 0", en_seen);
            end
        end
        for (int n = 0; n < 8; n++) step(1'b1, 32'(n), 1'b0);
        t_last = cyc;
        first_en = '{-1, -1};
        fd_at = '{-1, -1};
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'd0, 1'b0);
            o = cyc - t_last;
            for (int u = 0; u < 2; u++) begin
                if (en1_o[u] && first_en[u] < 0) first_en[u] = o;
                if (fd_o[u] && fd_at[u] < 0) fd_at[u] = o;
                if (o >= 1 && o <= 4) begin
                    c_d2[u][o-1] = d2_o[u];
                    c_w[u][o-1]  = w_o[u];
                end
                p = o - 1 - lat_of(u);
                if (p >= 0 && p <= 3) begin
                    c_d1[u][p]  = d1_o[u];
                    c_top[u][p] = top_o[u];
                    c_bot[u][p] = bot_o[u];
                end
            end
        end
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (first_en[u] != 1 || fd_at[u] != 4 + lat_of(u)) begin
                n_bad++;
                $display("FAIL kat_latency dut%0d: got en@%0d fd@%0d want en@1 fd@%0d", u, first_en[u], fd_at[u], 4 + lat_of(u));
            end
            for (int q = 0; q < 4; q++) begin
                n_cmp++;
                if (c_d2[u][q] !== 32'(x_d2[u][q]) || c_w[u][q] !== x_w[u][q] || c_d1[u][q] !== 32'(x_d1[u][q]) ||
                    c_top[u][q] !== 3'(x_top[u][q]) || c_bot[u][q] !== 3'(x_bot[u][q])) begin
                    n_bad++;
                    $display("FAIL kat_pair dut%0d p%0d: got d2=%h w=%h d1=%h (%0d,%0d) want d2=%h w=%h d1=%h (%0d,%0d)",
                             u, q, c_d2[u][q], c_w[u][q], c_d1[u][q], c_top[u][q], c_bot[u][q],
                             x_d2[u][q], x_w[u][q], x_d1[u][q], x_top[u][q], x_bot[u][q]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int rdy_drops, en_cnt [2], fd_cnt [2], fd_first [2], fd_last [2];
        en_cnt = '{0, 0};
        fd_cnt = '{0, 0};
        fd_first = '{-1, -1};
        fd_last = '{-1, -1};
        rdy_drops = 0;
        step(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            step(i < 16, $urandom, 1'b0);
            if (i < 16 && (!s_ready_o[0] || !s_ready_o[1])) rdy_drops++;
            for (int u = 0; u < 2; u++) begin
                if (en1_o[u]) en_cnt[u]++;
                if (fd_o[u]) begin
                    fd_cnt[u]++;
                    if (fd_first[u] < 0) fd_first[u] = cyc;
                    fd_last[u] = cyc;
                end
            end
        end
        n_cmp++;
        if (rdy_drops != 0) begin
            n_bad++;
            $display("FAIL b2b_ready: got %0d low cycles want 0", rdy_drops);
        end
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (en_cnt[u] != 8 || fd_cnt[u] != 2 || fd_last[u] - fd_first[u] != 8) begin
                n_bad++;
                $display("FAIL b2b_frames dut%0d: got en=%0d fd=%0d gap=%0d want 8,2,8", u, en_cnt[u], fd_cnt[u],
                         fd_last[u] - fd_first[u]);
            end
        end
    endtask

    task automatic test_random_stream;
        int f0, en_cnt [2];
        en_cnt = '{0, 0};
        step(1'b0, 32'd0, 1'b1);
        f0 = frames_sched;
        for (int i = 0; i < 160; i++) begin
            step((i < 24) || ($urandom_range(0, 3) != 0), $urandom, 1'b0);
            for (int u = 0; u < 2; u++) if (en1_o[u]) en_cnt[u]++;
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 32'd0, 1'b0);
            for (int u = 0; u < 2; u++) if (en1_o[u]) en_cnt[u]++;
        end
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (en_cnt[u] != 4 * (frames_sched - f0)) begin
                n_bad++;
                $display("FAIL stream_pairs dut%0d: got %0d want %0d", u, en_cnt[u], 4 * (frames_sched - f0));
            end
        end
    endtask

    task automatic test_delay_reset;
        int fd_cnt [2];
        fd_cnt = '{0, 0};
        step(1'b0, 32'd0, 1'b1);
        for (int n = 0; n < 8; n++) step(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 32'd0, 1'b0);
            for (int u = 0; u < 2; u++) if (fd_o[u]) fd_cnt[u]++;
        end
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (fd_cnt[u] != 0) begin
                n_bad++;
                $display("FAIL flushed_frame_done dut%0d: got %0d pulses want 0", u, fd_cnt[u]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_frame(0);
        test_back_to_back();
        test_random_stream();
        test_known_frame(5);
        test_delay_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
